// File: rtl/shared_or_arbiter_if.sv
// Request/response bundle for the shared OR datapath.
// The arbiter connects through the slave modport; the client side
// (requesters plus the result consumer) uses the master modport.
interface shared_or_arbiter_if #(
    parameter int NUM      = 4,
    parameter int BITS     = 32,
    parameter int CNT_BITS = 16
);
    localparam int IDW = (NUM > 1) ? $clog2(NUM) : 1;

    logic [NUM-1:0]      req_valid;
    logic [NUM-1:0]      req_ready;
    logic [NUM*BITS-1:0] req_a;
    logic [NUM*BITS-1:0] req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [BITS-1:0]     rsp_c;
    logic [IDW-1:0]      rsp_id;
    logic [CNT_BITS-1:0] served_cnt;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_c, rsp_id, served_cnt
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_c, rsp_id, served_cnt
    );
endinterface

// File: rtl/shared_or_arbiter.sv
// Shared OR datapath with round-robin arbitration among NUM requesters.
// One request is granted per cycle; its a|b result is held in a
// single-entry output buffer tagged with the requester index.
module shared_or_arbiter #(
    parameter int NUM      = 4,
    parameter int BITS     = 32,
    parameter int CNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    shared_or_arbiter_if.slave    bus
);
    localparam int IDW = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } buf_state_e;

    buf_state_e          state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [BITS-1:0]     c_q, c_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    logic                can_accept;
    logic                grant_vld;
    logic [IDW-1:0]      win_idx;
    logic [NUM-1:0]      ready;

    // The shared OR datapath every requester used to own privately.
    function automatic logic [BITS-1:0] or_gate(input logic [BITS-1:0] a,
                                                input logic [BITS-1:0] b);
        return a | b;
    endfunction

    // Index base+off wrapped into 0..NUM-1 (off never exceeds NUM).
    function automatic int wrap_idx(input int base, input int off);
        int sum;
        sum = base + off;
        return (sum >= NUM) ? sum - NUM : sum;
    endfunction

    // Round-robin pick: first valid requester at or after the pointer.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        ready      = '0;
        grant_vld  = 1'b0;
        win_idx    = '0;
        // A draining result frees the buffer in the same cycle.
        can_accept = !rst && ((state_q == S_EMPTY) || bus.rsp_ready);
        for (int off = 0; off < NUM; off++) begin
            if (can_accept && !grant_vld && bus.req_valid[wrap_idx(int'(ptr_q), off)]) begin
                grant_vld = 1'b1;
                win_idx   = IDW'(wrap_idx(int'(ptr_q), off));
            end
        end
        if (grant_vld) begin
            ready[win_idx] = 1'b1;
        end
    end

    // Buffer fill/drain, pointer advance and served counter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        if (grant_vld) begin
            state_d = S_FULL;
            c_d     = or_gate(bus.req_a[int'(win_idx)*BITS +: BITS],
                              bus.req_b[int'(win_idx)*BITS +: BITS]);
            id_d    = win_idx;
            ptr_d   = IDW'(wrap_idx(int'(win_idx), 1));
            cnt_d   = cnt_q + 1'b1;
        end else if ((state_q == S_FULL) && bus.rsp_ready) begin
            // Result consumed with nothing to replace it; c/id keep last value.
            state_d = S_EMPTY;
        end
    end

    // State registers with synchronous reset that discards any held result.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all flops updating from the
        // same pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= S_EMPTY;
            ptr_q   <= '0;
            id_q    <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.rsp_valid  = (state_q == S_FULL);
    assign bus.rsp_c      = c_q;
    assign bus.rsp_id     = id_q;
    assign bus.served_cnt = cnt_q;
endmodule

// File: tb/tb_shared_or_arbiter.sv
// Directed and randomized bench for shared_or_arbiter against a
// transaction-level reference model of the arbiter and result buffer.
module tb_shared_or_arbiter;
    localparam int NUM      = 4;
    localparam int BITS     = 32;
    localparam int CNT_BITS = 4;

    logic clk = 1'b0;
    logic rst;

    shared_or_arbiter_if #(.NUM(NUM), .BITS(BITS), .CNT_BITS(CNT_BITS)) bus ();

    shared_or_arbiter #(.NUM(NUM), .BITS(BITS), .CNT_BITS(CNT_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [BITS-1:0] a_op [NUM];
    logic [BITS-1:0] b_op [NUM];

    // Reference model: what the response channel should show.
    bit              m_valid = 1'b0;
    logic [BITS-1:0] m_c     = '0;
    int              m_id    = 0;
    int              m_ptr   = 0;
    int              m_cnt   = 0;

    logic [NUM-1:0]  last_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check grant before the edge,
    // advance the model at the edge, check the response after it.
    task automatic step(input logic [NUM-1:0] v, input logic rr, input logic r);
        int w;
        logic [NUM-1:0] exp_ready;
        rst           = r;
        bus.rsp_ready = rr;
        bus.req_valid = v;
        for (int i = 0; i < NUM; i++) begin
            bus.req_a[i*BITS +: BITS] = a_op[i];
            bus.req_b[i*BITS +: BITS] = b_op[i];
        end
        #1;
        w = -1;
        if (!r && (!m_valid || rr)) begin
            for (int k = 0; k < NUM; k++) begin
                if (w < 0 && v[(m_ptr + k) % NUM]) w = (m_ptr + k) % NUM;
            end
        end
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        last_ready = bus.req_ready;
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0;
            m_c     = '0;
            m_id    = 0;
            m_ptr   = 0;
            m_cnt   = 0;
        end else if (w >= 0) begin
            m_valid = 1'b1;
            m_c     = a_op[w] | b_op[w];
            m_id    = w;
            m_ptr   = (w + 1) % NUM;
            m_cnt   = (m_cnt + 1) % (1 << CNT_BITS);
        end else if (m_valid && rr) begin
            m_valid = 1'b0;
        end
        #1;
        check("rsp_valid",  64'(bus.rsp_valid),  64'(m_valid));
        check("rsp_c",      64'(bus.rsp_c),      64'(m_c));
        check("rsp_id",     64'(bus.rsp_id),     64'(m_id));
        check("served_cnt", 64'(bus.served_cnt), 64'(m_cnt));
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
        end
        @(negedge clk);

        // Reset held with every requester asking.
        repeat (3) step(4'b1111, 1'b1, 1'b1);
        check("reset_ready", 64'(last_ready), 64'h0);
        step(4'b0000, 1'b1, 1'b0);
        check("post_reset_valid", 64'(bus.rsp_valid), 64'h0);
        check("post_reset_cnt", 64'(bus.served_cnt), 64'h0);

        // Single request from requester 2.
        a_op[2] = 32'h0000_00F0;
        b_op[2] = 32'h0000_000F;
        step(4'b0100, 1'b1, 1'b0);
        check("single_ready", 64'(last_ready), 64'h4);
        check("single_c", 64'(bus.rsp_c), 64'hFF);
        check("single_id", 64'(bus.rsp_id), 64'h2);
        check("single_cnt", 64'(bus.served_cnt), 64'h1);

        // Full contention from a fresh pointer.
        step(4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < NUM; i++) begin
            a_op[i] = 32'h1 << i;
            b_op[i] = 32'h100 << i;
        end
        step(4'b1111, 1'b1, 1'b0);
        check("contend_first", 64'(last_ready), 64'h1);
        repeat (7) step(4'b1111, 1'b1, 1'b0);
        check("contend_last_c", 64'(bus.rsp_c), 64'h808);

        // Backpressure with a held result from requester 1.
        a_op[1] = 32'h1;
        b_op[1] = 32'h2;
        step(4'b0010, 1'b1, 1'b0);
        check("bp_fill_c", 64'(bus.rsp_c), 64'h3);
        repeat (4) step(4'b1111, 1'b0, 1'b0);
        check("bp_hold_c", 64'(bus.rsp_c), 64'h3);
        check("bp_hold_id", 64'(bus.rsp_id), 64'h1);
        step(4'b1111, 1'b1, 1'b0);
        check("bp_release_ready", 64'(last_ready), 64'h4);
        check("bp_release_id", 64'(bus.rsp_id), 64'h2);

        // Fairness wrap across the top index.
        step(4'b1000, 1'b1, 1'b0);
        step(4'b1001, 1'b1, 1'b0);
        check("wrap_to_0", 64'(last_ready), 64'h1);
        step(4'b1001, 1'b1, 1'b0);
        check("wrap_to_3", 64'(last_ready), 64'h8);

        // Randomized traffic and backpressure.
        for (int n = 0; n < 80; n++) begin
            for (int i = 0; i < NUM; i++) begin
                a_op[i] = $urandom;
                b_op[i] = $urandom;
            end
            step(NUM'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'b0);
        end

        // Counter wrap, then reset while a result is stalled.
        step(4'b0000, 1'b1, 1'b1);
        repeat (17) step(4'b1111, 1'b1, 1'b0);
        check("cnt_wrap", 64'(bus.served_cnt), 64'h1);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1);
        check("mid_reset_valid", 64'(bus.rsp_valid), 64'h0);
        check("mid_reset_cnt", 64'(bus.served_cnt), 64'h0);
        step(4'b1111, 1'b1, 1'b0);
        check("mid_reset_ptr", 64'(last_ready), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
